// File: rtl/cbox_pkg.sv
// Shared widths and arbiter state encoding for
// the register-file write-back path.
package cbox_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_B = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO holding long-latency results
// (destination register + data) awaiting the write port.
import cbox_pkg::*;

module wb_fifo2 #(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] ws_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW-1:0] head_ws_o,
  output logic [DW-1:0] head_data_o
);

  logic [AW-1:0] ws_q   [2];
  logic [DW-1:0] data_q [2];
  logic          wr_q;
  logic          rd_q;
  logic [1:0]    cnt_q;
  logic [1:0]    cnt_d;
  logic          push;
  logic          pop;

  assign full_o      = (cnt_q == 2'd2);
  assign empty_o     = (cnt_q == 2'd0);
  assign push        = push_i && !full_o;
  assign pop         = pop_i && !empty_o;
  assign head_ws_o   = ws_q[rd_q];
  assign head_data_o = data_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= 2'd0;
      ws_q[0]   <= '0;
      ws_q[1]   <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else begin
      if (push) begin
        ws_q[wr_q]   <= ws_i;
        data_q[wr_q] <= data_i;
        wr_q         <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the register-file write port between the pipeline
// (A) and buffered long-latency results (B); tracks busy regs.
import cbox_pkg::*;

module wb_arbiter #(
  parameter int DW           = DATA_W,
  parameter int AW           = REG_AW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              HALT,
  input  logic              A_VALID,
  input  logic [AW-1:0]     A_WS,
  input  logic [DW-1:0]     A_DATA,
  output logic              A_READY,
  input  logic              B_VALID,
  input  logic [AW-1:0]     B_WS,
  input  logic [DW-1:0]     B_DATA,
  output logic              B_READY,
  input  logic              ISSUE_VALID,
  input  logic [AW-1:0]     ISSUE_WS,
  output logic [AW-1:0]     WS,
  output logic              WE,
  output logic [DW-1:0]     IN,
  output logic [2**AW-1:0]  BUSY,
  output logic              ERR
);

  localparam int AGW =
    (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [AGW-1:0] AGE_MAX =
    AGW'(STARVE_LIMIT - 1);

  arb_state_t        state_q, state_d;
  logic [AGW-1:0]    age_q, age_d;
  logic [2**AW-1:0]  busy_q, busy_d;
  logic              err_q, err_d;
  logic              we_q;
  logic [AW-1:0]     ws_q;
  logic [DW-1:0]     in_q;

  logic              full;
  logic              empty;
  logic [AW-1:0]     head_ws;
  logic [DW-1:0]     head_data;
  logic              a_ready;
  logic              grant_a;
  logic              grant_b;

  wb_fifo2 #(
    .DW (DW),
    .AW (AW)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (RST_N),
    .push_i      (B_VALID),
    .pop_i       (grant_b),
    .ws_i        (B_WS),
    .data_i      (B_DATA),
    .full_o      (full),
    .empty_o     (empty),
    .head_ws_o   (head_ws),
    .head_data_o (head_data)
  );

  assign A_READY = a_ready;
  assign B_READY = !full;

  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    a_ready = 1'b0;
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (state_q)
      NORMAL: begin
        a_ready = !HALT && !full;
        grant_a = A_VALID && a_ready;
        grant_b = !grant_a && !empty && !HALT;
        if (!HALT) begin
          if (empty || grant_b) begin
            age_d = '0;
          end else if (age_q == AGE_MAX) begin
            age_d   = '0;
            state_d = FORCE_B;
          end else begin
            age_d = age_q + AGW'(1);
          end
        end
      end
      FORCE_B: begin
        grant_b = !HALT && !empty;
        if (!HALT) begin
          age_d   = '0;
          state_d = NORMAL;
        end
      end
      default: begin
        state_d = NORMAL;
        age_d   = '0;
      end
    endcase
  end

  // a same-cycle issue to the register being retired wins
  always_comb begin
    busy_d = busy_q;
    if (grant_b) begin
      busy_d[head_ws] = 1'b0;
    end
    if (ISSUE_VALID) begin
      busy_d[ISSUE_WS] = 1'b1;
    end
    err_d = err_q || (ISSUE_VALID && busy_q[ISSUE_WS]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= NORMAL;
      age_q   <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      ws_q    <= '0;
      in_q    <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      we_q    <= grant_a || grant_b;
      if (grant_a) begin
        ws_q <= A_WS;
        in_q <= A_DATA;
      end else if (grant_b) begin
        ws_q <= head_ws;
        in_q <= head_data;
      end
    end
  end

  assign WS   = ws_q;
  assign WE   = we_q;
  assign IN   = in_q;
  assign BUSY = busy_q;
  assign ERR  = err_q;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and scoreboard for the 16-bit, 8-entry register file. It shares the register file's single write port between two writers: the in-order pipeline write-back stage (A) and the long-latency unit (B, loads/multiply). B results go through a 2-entry FIFO. The block also tracks registers with outstanding B results so decode can stall on them.

## Interface
Parameters:
- DW, 16, data width
- AW, 3, register-select width (8 registers)
- STARVE_LIMIT, 4, cycles a non-empty B FIFO may wait before B is forced

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- HALT  in  1  freezes all grants and pops
- A_VALID  in  1  pipeline write-back request
- A_WS  in  AW  destination register
- A_DATA  in  DW  write data
- A_READY  out  1  A accepted when A_VALID && A_READY
- B_VALID  in  1  long-latency unit result
- B_WS  in  AW  destination register
- B_DATA  in  DW  write data
- B_READY  out  1  B pushed into the FIFO when B_VALID && B_READY
- ISSUE_VALID  in  1  long-latency op issued
- ISSUE_WS  in  AW  its destination register
- WS  out  AW  to register-file WS
- WE  out  1  to register-file WE
- IN  out  DW  to register-file IN
- BUSY  out  8  one bit per register with a B result pending
- ERR  out  1  sticky; issue made to an already-busy register

## Operation
- FIFO: 2 entries. B_READY = !full.
  - Push when B_VALID && B_READY.
  - Pop when B is granted.
  - Push and pop in the same cycle with 1 entry: occupancy stays 1.
- Arbiter FSM has two states, NORMAL and FORCE_B.
  - NORMAL: A_READY = !HALT && !full.
    - If A_VALID && A_READY, grant A.
    - Otherwise, if the FIFO is non-empty and !HALT, grant the FIFO head.
    - When full and not halted, the FIFO head is granted and A waits.
  - Starvation counter age:
    - Increments each cycle the FIFO is non-empty, B is not granted and !HALT.
    - Clears on a B grant or when the FIFO is empty.
    - When age == STARVE_LIMIT-1 and B is not granted, go to FORCE_B next cycle.
  - FORCE_B: A_READY = 0. Grant the FIFO head (non-empty is guaranteed). Clear age and return to NORMAL.
  - If HALT is high in FORCE_B, stay there with no grant until HALT drops.
- HALT: no grants and no pops. FIFO pushes continue. age is frozen. A_READY = 0.
- A_READY and B_READY depend only on state, never on A_VALID or B_VALID.
- Scoreboard:
  - ISSUE_VALID sets BUSY[ISSUE_WS].
  - A B grant clears BUSY[head WS].
  - Set and clear of the same register in one cycle: set wins.
  - ISSUE_VALID to a register whose BUSY bit is already 1 sets ERR. ERR is cleared only by reset.
  - A writes never touch BUSY.

## Timing
- Reset values: WE=0, WS=0, IN=0, BUSY=0, ERR=0, FIFO empty, state NORMAL, age=0. Hence B_READY=1, and A_READY=1 unless HALT.
- WS, WE and IN are registered.
  - A grant at edge n drives WE=1 with that WS/IN during cycle n+1; the register file writes at edge n+1.
  - With no grant, WE=0 the next cycle. WS and IN hold their last values.
- One write per cycle at most. Back-to-back grants give a continuous WE.
- B latency from push to WE is at least 2 cycles (push edge, grant edge).
- BUSY updates at the grant edge, one cycle before WE. Decode may re-issue once BUSY clears, because the write lands before any read of the new op.
- RST_N asserted mid-operation asynchronously discards FIFO contents and any in-flight write; WE falls immediately.

## Structure
- Shared package cbox_pkg holds DATA_W=16, REG_AW=3, NUM_REGS=8, and the enum arb_state_t {NORMAL, FORCE_B}.
- Sub-module wb_fifo2 is the 2-entry FIFO: push/pop, full/empty, head WS/DATA, same async active-low reset.
- Arbiter FSM, age counter, scoreboard and output registers live in wb_arbiter.

## Test plan
- Reset, then A_VALID with A_WS=3, A_DATA=0x1234 -> next cycle WE=1, WS=3, IN=0x1234; register 3 reads 0x1234 afterwards.
- ISSUE_WS=5, then B_VALID with B_WS=5, B_DATA=0xBEEF and A idle -> BUSY[5]=1 until the grant edge; WE=1, WS=5, IN=0xBEEF two cycles after the push; BUSY=0 after.
- A_VALID held continuously while B is pushed once -> after 4 cycles A_READY=0 for one cycle and B is written; age resets; A resumes the next cycle.
- B pushes 3 consecutive cycles while A is held valid -> B_READY=0 once the FIFO is full; the FIFO head is granted the following cycle; no B data lost or reordered.
- HALT=1 with A valid and 2 B pushes -> WE stays 0, FIFO full, B_READY=0; after HALT=0 the FIFO head (B) is granted next cycle.
- ISSUE_WS=2 twice without a B write in between -> ERR=1 and it stays 1; RST_N pulsed low mid-stream -> WE=0 immediately, BUSY=0, ERR=0, FIFO empty.
